// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - FSM state encoding and UART frame constants for fifo_uart_tx
package fifo_uart_tx_pkg;

    localparam int   DATA_W      = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing one tick per serial bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_tick = run && (cnt_q == LAST);
        cnt_d    = cnt_q + CW'(1);
        if (!run || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter pulling one byte per frame from a synchronous FIFO
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                stop_idx_q, stop_idx_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                rd_en_q, rd_en_d;
    logic                run;
    logic                bit_tick;

    assign run = (state_q == START) || (state_q == DATA) ||
                 (state_q == PARITY) || (state_q == STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .bit_tick(bit_tick)
    );

    // tx_d always carries the level of the bit being entered, so tx changes on
    // the same edge as the state register.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        rd_en_d    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                end
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d    = fifo_dout;
                parity_d   = even_parity(fifo_dout);
                bit_idx_d  = 3'd0;
                stop_idx_d = 1'b0;
                tx_d       = START_LEVEL;
                state_d    = START;
            end
            START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = STOP_LEVEL;
                            state_d = STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    tx_d    = STOP_LEVEL;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (int'(stop_idx_q) == STOP_BITS - 1) begin
                        frame_done = 1'b1;
                        tx_d       = IDLE_LEVEL;
                        state_d    = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            rd_en_q    <= rd_en_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);

endmodule
